// File: rtl/ifetch_queue_if.sv
// Instruction-fetch bus bundle: memory read port, branch redirect and the
// decode-side valid/ready handshake. master = fetch queue, slave = environment.
interface ifetch_queue_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              read_mem_ir;
    logic [ADDR_W-1:0] mem_radrs_ir;
    logic [DATA_W-1:0] instruction_fetch;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_address;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output read_mem_ir, mem_radrs_ir, instr_out, instr_pc, instr_valid,
        input  instruction_fetch, branch_valid, branch_address, instr_ready
    );

    modport slave (
        input  read_mem_ir, mem_radrs_ir, instr_out, instr_pc, instr_valid,
        output instruction_fetch, branch_valid, branch_address, instr_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues reads to a
// fixed-latency instruction memory, tracks reads in flight and buffers the
// returned words in a prefetch FIFO feeding decode. A branch redirect kills
// everything fetched on the wrong path.
// Optional macro IFETCH_PERF_EN adds saturating perf_fetched/perf_flushed counters.
module ifetch_queue #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic resetn,
    ifetch_queue_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_flushed
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = $clog2(DEPTH + MEM_LAT + 2) + 1;

    typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

    state_t            state, state_nxt;
    logic              issue;
    logic [ADDR_W-1:0] pc;

    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    // In-flight tracker: busy holds the credit, live says the word is wanted.
    logic [MEM_LAT-1:0] tk_busy, tk_live;
    logic [ADDR_W-1:0]  tk_pc [MEM_LAT];

    logic [SUM_W-1:0] occupancy;
    logic             tail_busy, tail_live, push, pop;

    assign tail_busy = tk_busy[MEM_LAT-1];
    assign tail_live = tk_live[MEM_LAT-1];
    assign push      = tail_busy && tail_live && !bus.branch_valid;
    assign pop       = (count != '0) && bus.instr_ready && !bus.branch_valid;

    assign bus.instr_valid = (count != '0);
    assign bus.instr_out   = bus.instr_valid ? fifo_data[rd_ptr] : '0;
    assign bus.instr_pc    = bus.instr_valid ? fifo_pc[rd_ptr]   : '0;

    // Credits in use: buffered words plus every read still owed by the memory.
    always_comb begin
        occupancy = SUM_W'(count) + SUM_W'(bus.read_mem_ir);
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
            occupancy = occupancy + SUM_W'(tk_busy[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= BOOT;
        else         state <= state_nxt;
    end

    // FSM next state and read-issue decision; a redirect overrides everything.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        if (bus.branch_valid) begin
            state_nxt = REDIRECT;
        end else begin
            case (state)
                BOOT:     state_nxt = RUN;
                REDIRECT: state_nxt = RUN;
                RUN: begin
                    state_nxt = RUN;
                    issue     = (occupancy < SUM_W'(DEPTH));
                end
                default:  state_nxt = BOOT;
            endcase
        end
    end

    // Fetch PC, registered read port, tracker shift and FIFO bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc               <= '0;
            bus.read_mem_ir  <= 1'b0;
            bus.mem_radrs_ir <= '0;
            tk_busy          <= '0;
            tk_live          <= '0;
            for (int unsigned i = 0; i < MEM_LAT; i++) tk_pc[i] <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
        end else begin
            bus.read_mem_ir <= issue;
            if (issue) bus.mem_radrs_ir <= pc;

            if (bus.branch_valid) pc <= bus.branch_address;
            else if (issue)       pc <= pc + ADDR_W'(1);

            tk_busy[0] <= bus.read_mem_ir;
            tk_live[0] <= bus.read_mem_ir && !bus.branch_valid;
            tk_pc[0]   <= bus.mem_radrs_ir;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tk_busy[i] <= tk_busy[i-1];
                tk_live[i] <= tk_live[i-1] && !bus.branch_valid;
                tk_pc[i]   <= tk_pc[i-1];
            end

            if (bus.branch_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (!push && pop) count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.instruction_fetch;
            fifo_pc[wr_ptr]   <= tk_pc[MEM_LAT-1];
        end
    end

`ifdef IFETCH_PERF_EN
    logic [16:0] flush_inc, flush_sum;

    // Words lost this edge: a retiring killed read, plus the FIFO on redirect.
    always_comb begin
        flush_inc = '0;
        if (tail_busy && (!tail_live || bus.branch_valid)) flush_inc = 17'd1;
        if (bus.branch_valid) flush_inc = flush_inc + 17'(count);
        flush_sum = {1'b0, perf_flushed} + flush_inc;
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            perf_flushed <= flush_sum[16] ? '1 : flush_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: two lanes (MEM_LAT=1 and MEM_LAT=3)
// share clock, reset and branch stimulus; each lane has its own memory model,
// expected-PC queue and delivery monitor that drives instr_ready.
module tb_ifetch_queue;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              br_valid;
    logic [ADDR_W-1:0] br_addr;
    bit                go;
    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;

    logic [ADDR_W-1:0] exp_q [2][$];

    logic              lane_rd    [2];
    logic [ADDR_W-1:0] lane_adr   [2];
    logic [ADDR_W-1:0] lane_pc    [2];
    logic [DATA_W-1:0] lane_out   [2];
    logic              lane_valid [2];
    logic              lane_ready [2];
    int                lane_reads [2];
    int                lane_gaps  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 5'b0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    generate
        for (genvar k = 0; k < 2; k++) begin : g_lane
            localparam int LAT = (k == 0) ? 1 : 3;

            ifetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef IFETCH_PERF_EN
            logic [31:0] perf_fetched;
            logic [15:0] perf_flushed;
`endif
            ifetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_LAT(LAT)) u_dut (
                .clk    (clk),
                .resetn (resetn),
                .bus    (bus)
`ifdef IFETCH_PERF_EN
                ,
                .perf_fetched (perf_fetched),
                .perf_flushed (perf_flushed)
`endif
            );

            assign bus.branch_valid   = br_valid;
            assign bus.branch_address = br_addr;

            // Fixed-latency memory: not reset, so stale reads still come back.
            logic [ADDR_W:0] mpipe [LAT];
            always @(posedge clk) begin
                mpipe[0] <= {bus.read_mem_ir, bus.mem_radrs_ir};
                for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
            end
            assign bus.instruction_fetch = mpipe[LAT-1][ADDR_W] ?
                                           mem_word(mpipe[LAT-1][ADDR_W-1:0]) : 32'hDEAD_BEEF;

            int reads = 0;
            always @(negedge clk) if (bus.read_mem_ir) reads <= reads + 1;

            int gaps     = 0;
            int last_acc = -100;

            // Monitor: compare each accepted word against the lane's queue.
            initial begin
                logic [ADDR_W-1:0] e;
                bus.instr_ready = 1'b0;
                forever begin
                    @(negedge clk);
                    if (resetn && bus.instr_valid && bus.instr_ready && !br_valid) begin
                        if (exp_q[k].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL lane%0d extra_word: got pc 0x%0h, required no delivery", k, bus.instr_pc);
                        end else begin
                            e = exp_q[k].pop_front();
                            check($sformatf("lane%0d pc", k), 32'(bus.instr_pc), 32'(e));
                            check($sformatf("lane%0d out", k), bus.instr_out, mem_word(e));
                        end
                        if (cyc != last_acc + 1) gaps++;
                        last_acc = cyc;
                    end
                    @(posedge clk);
                    #1;
                    bus.instr_ready = go && (exp_q[k].size() != 0);
                end
            end

            assign lane_rd[k]    = bus.read_mem_ir;
            assign lane_adr[k]   = bus.mem_radrs_ir;
            assign lane_pc[k]    = bus.instr_pc;
            assign lane_out[k]   = bus.instr_out;
            assign lane_valid[k] = bus.instr_valid;
            assign lane_ready[k] = bus.instr_ready;
            assign lane_reads[k] = reads;
            assign lane_gaps[k]  = gaps;
        end
    endgenerate

    task automatic push_both(input logic [ADDR_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q[0].push_back(first + ADDR_W'(i));
            exp_q[1].push_back(first + ADDR_W'(i));
        end
    endtask

    task automatic flush_both();
        exp_q[0].delete();
        exp_q[1].delete();
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < max) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending %0d/%0d words after %0d cycles, required 0",
                     exp_q[0].size(), exp_q[1].size(), n);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s lane%0d read_mem_ir", tag, k), 32'(lane_rd[k]), 0);
            check($sformatf("%s lane%0d mem_radrs_ir", tag, k), 32'(lane_adr[k]), 0);
            check($sformatf("%s lane%0d instr_valid", tag, k), 32'(lane_valid[k]), 0);
            check($sformatf("%s lane%0d instr_out", tag, k), lane_out[k], 0);
            check($sformatf("%s lane%0d instr_pc", tag, k), 32'(lane_pc[k]), 0);
        end
    endtask

    initial begin
        int first_rd [2];
        int first_v  [2];
        int first_ad [2];
        int g0;

        resetn   = 1'b0;
        br_valid = 1'b0;
        br_addr  = '0;
        go       = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_zero_outputs("reset");

        // Fill with decode stalled: latency, exactly DEPTH reads, head = 0.
        resetn = 1'b1;
        first_rd = '{-1, -1};
        first_v  = '{-1, -1};
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 2; k++) begin
                if (first_rd[k] < 0 && lane_rd[k])    first_rd[k] = i;
                if (first_v[k] < 0 && lane_valid[k])  first_v[k]  = i;
            end
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("lane%0d read_to_valid", k), 32'(first_v[k] - first_rd[k]), (k == 0) ? 2 : 4);
            check($sformatf("lane%0d stalled_reads", k), 32'(lane_reads[k]), DEPTH);
            check($sformatf("lane%0d stalled_rd_idle", k), 32'(lane_rd[k]), 0);
            check($sformatf("lane%0d stalled_valid", k), 32'(lane_valid[k]), 1);
            check($sformatf("lane%0d stalled_head_pc", k), 32'(lane_pc[k]), 0);
            check($sformatf("lane%0d stalled_head_out", k), lane_out[k], mem_word('0));
        end

        // Release decode for 10 words; MEM_LAT=1 lane must stream back to back.
        g0 = lane_gaps[0];
        push_both('0, 10);
        go = 1'b1;
        wait_drain(200);
        check("lane0 back_to_back", 32'(lane_gaps[0] - g0), 1);
        repeat (15) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("lane%0d refill_reads", k), 32'(lane_reads[k]), 14);
            check($sformatf("lane%0d refill_rd_idle", k), 32'(lane_rd[k]), 0);
            check($sformatf("lane%0d refill_head_pc", k), 32'(lane_pc[k]), 10);
        end

        // Branch on the same edge as the pop of pc 11; target wraps the space.
        push_both(ADDR_W'(10), 2);
        @(posedge clk); #2;
        @(posedge clk); #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("lane%0d pop_head_pc", k), 32'(lane_pc[k]), 11);
            check($sformatf("lane%0d pop_ready", k), 32'(lane_ready[k]), 1);
        end
        br_valid = 1'b1;
        br_addr  = ADDR_W'(11'h7FE);
        flush_both();
        exp_q[0].push_back(11'h7FE); exp_q[1].push_back(11'h7FE);
        exp_q[0].push_back(11'h7FF); exp_q[1].push_back(11'h7FF);
        push_both('0, 4);
        @(posedge clk); #2;
        br_valid = 1'b0;
        wait_drain(200);

        // Redirect while reads are in flight, then a two-cycle redirect
        // whose second target must win.
        repeat (5) @(posedge clk);
        #2;
        br_valid = 1'b1;
        br_addr  = ADDR_W'(11'h200);
        @(posedge clk); #2;
        br_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        br_valid = 1'b1;
        br_addr  = ADDR_W'(11'h300);
        push_both(ADDR_W'(11'h100), 6);
        @(posedge clk); #2;
        br_addr  = ADDR_W'(11'h100);
        @(posedge clk); #2;
        br_valid = 1'b0;
        first_ad = '{-1, -1};
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < 2; k++)
                if (first_ad[k] < 0 && lane_rd[k]) first_ad[k] = int'(lane_adr[k]);
            @(posedge clk);
            #2;
        end
        for (int k = 0; k < 2; k++)
            check($sformatf("lane%0d first_read_after_redirect", k), 32'(first_ad[k]), 32'h100);
        wait_drain(200);

        // Asynchronous reset mid-stream; stale memory returns must be ignored.
        push_both(ADDR_W'(11'h106), 10);
        repeat (4) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        flush_both();
        push_both('0, 6);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        wait_drain(200);

        for (int k = 0; k < 2; k++)
            check($sformatf("lane%0d leftover_expected", k), 32'(exp_q[k].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined cpu core.
- Owns the fetch PC and drives the instruction memory read port (read_mem_ir / mem_radrs_ir).
- Tracks reads still in flight in the fixed-latency memory and buffers returned words in a small prefetch FIFO.
- Presents instructions to the decode stage with a valid/ready handshake. A branch redirect flushes everything fetched on the wrong path.

Parameters:
- ADDR_W, 11, fetch address width (2048-word instruction space)
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries (power of two, 2..16)
- MEM_LAT, 1, cycles from read_mem_ir high to instruction_fetch valid (1..4)

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- read_mem_ir  out  1  instruction memory read enable (registered)
- mem_radrs_ir  out  ADDR_W  instruction read address (registered)
- instruction_fetch  in  DATA_W  read data, valid MEM_LAT cycles after the read
- branch_valid  in  1  redirect request from the core
- branch_address  in  ADDR_W  redirect target
- instr_out  out  DATA_W  FIFO head instruction; 0 (NOOP) when empty
- instr_pc  out  ADDR_W  address of instr_out; 0 when empty
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  decode accepts the head this cycle

Behaviour:
- Reset (async, resetn=0) clears all state immediately:
  - read_mem_ir=0, mem_radrs_ir=0, instr_valid=0, instr_out=0, instr_pc=0
  - FIFO empty, in-flight tracker cleared, fetch PC=0, FSM=BOOT
- FSM has three states:
  - BOOT: one cycle after reset release, no read issued; next state RUN.
  - RUN: a read is issued when (fifo_count + inflight) < DEPTH, both sampled from registers; no same-cycle pop bypass.
    - An issued read sets read_mem_ir=1 and mem_radrs_ir=PC, then PC increments by 1.
    - PC wraps from 2^ADDR_W-1 to 0.
  - REDIRECT: entered when branch_valid=1 in RUN or BOOT.
    - On that edge: PC<=branch_address, FIFO cleared, every in-flight entry marked killed.
    - read_mem_ir=0 for the REDIRECT cycle; next state RUN, and the first read goes to branch_address.
    - branch_valid while already in REDIRECT re-captures the new target and stays in REDIRECT for one more cycle.
- In-flight tracker:
  - MEM_LAT-deep shift register of {live, pc} entries.
  - A read issued in cycle N (read_mem_ir high) is captured from instruction_fetch at the end of cycle N+MEM_LAT.
  - The captured word is pushed with its pc only if the entry is still live.
  - Killed entries are dropped, and their credit returns on that same edge.
- Timing and handshake:
  - Fetch-to-valid latency is MEM_LAT+1 cycles from the read cycle to instr_valid.
  - Pop occurs when instr_valid && instr_ready; the head advances on that edge.
  - instr_out and instr_pc are driven from registered FIFO storage, with no combinational path from instruction_fetch.
- Boundary conditions:
  - Full: the credit rule guarantees a returning word always has a slot; overflow is impossible.
  - instr_ready with empty FIFO: ignored.
  - Push and pop on the same edge: both happen, count unchanged.
  - branch_valid together with a pop or push on the same edge: the branch wins; FIFO cleared, pop and push discarded.
  - resetn asserted mid-fetch: outstanding reads are abandoned; data returning after reset release is not captured, because the tracker is empty.

Optional Feature:
- Macro: IFETCH_PERF_EN
- Defined:
  - Adds output perf_fetched (32-bit), counting words pushed to the FIFO.
  - Adds output perf_flushed (16-bit), counting words dropped as killed or cleared from the FIFO on redirect.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port exists and no counters are built.

Test Plan:
- Reset release, instr_ready=1, MEM_LAT=1, memory returns word=address → reads at addresses 0,1,2,3…; instr_valid first high 2 cycles after the first read; instr_out/instr_pc = 0/0, 1/1, 2/2 on consecutive cycles.
- instr_ready=0 held → exactly DEPTH=4 reads issued, then read_mem_ir=0; FIFO holds addresses 0..3. Raise instr_ready → one pop per cycle and reads resume, one per freed slot.
- MEM_LAT=3, branch_valid=1 with branch_address=0x100 while 3 reads are in flight → killed words never appear; first valid instr_pc=0x100; perf_flushed (if IFETCH_PERF_EN) increments by 3 plus the FIFO occupancy.
- branch_address=0x7FE, instr_ready=1 → instr_pc sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Branch on the same edge as a pop → popped head not counted as delivered; next valid instr_pc = branch target.
- resetn pulsed low mid-stream with MEM_LAT=2 → all outputs 0 immediately, even without a clock edge; after release, the first delivered instr_pc = 0 and no stale word is delivered.
